// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer:
// register map, counter-word layout, FSM state encoding.
package pll_reconfig_pkg;

  localparam logic [5:0] ADDR_MODE   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_START  = 6'h02;
  localparam logic [5:0] ADDR_N      = 6'h03;
  localparam logic [5:0] ADDR_M      = 6'h04;
  localparam logic [5:0] ADDR_C      = 6'h05;
  localparam logic [5:0] ADDR_DPS    = 6'h06;
  localparam logic [5:0] ADDR_K      = 6'h07;

  localparam int CNT_W       = 18;
  localparam int CNT_LO_LSB  = 0;
  localparam int CNT_HI_LSB  = 8;
  localparam int CNT_BYP_BIT = 16;
  localparam int CNT_ODD_BIT = 17;

  localparam int PH_W = 17;

  typedef struct packed {
    logic       odd;
    logic       bypass;
    logic [7:0] hi;
    logic [7:0] lo;
  } cnt_word_t;

  typedef enum logic [3:0] {
    IDLE,
    WR_MODE,
    WR_N,
    WR_M,
    WR_K,
    WR_C,
`ifdef PLL_RCFG_DPS_EN
    WR_DPS,
`endif
    WR_START,
    WAIT_RCFG,
    WAIT_LOCK
  } state_e;

  // N/M register data: counter word in the low 18 bits.
  function automatic logic [31:0] cnt_data(
    input cnt_word_t w
  );
    logic [31:0] d;
    d = '0;
    d[CNT_LO_LSB +: 8] = w.lo;
    d[CNT_HI_LSB +: 8] = w.hi;
    d[CNT_BYP_BIT]     = w.bypass;
    d[CNT_ODD_BIT]     = w.odd;
    return d;
  endfunction

endpackage

// File: rtl/pll_reconfig_seq_lock.sv
// Lock monitor: 2-flop synchroniser for pll_locked, saturating
// stability counter and saturating timeout counter.
// Ports: clk, reset_n; i_stab_en (count stability),
// i_to_clr / i_to_en (timeout control); o_stable / o_timeout
// are high on the cycle whose edge makes the counter reach its
// limit.
module pll_lock_monitor
  import pll_reconfig_pkg::*;
#(
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 1048576
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_locked,
  input  logic i_stab_en,
  input  logic i_to_clr,
  input  logic i_to_en,
  output logic o_stable,
  output logic o_timeout
);

  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [SW-1:0] r_stab_cnt;
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_locked;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stab_cnt <= '0;
    end else if (!i_stab_en || !r_sync2) begin
      r_stab_cnt <= '0;
    end else if (r_stab_cnt != SW'(LOCK_STABLE)) begin
      r_stab_cnt <= r_stab_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (i_to_clr) begin
      r_to_cnt <= '0;
    end else if (i_to_en &&
                 r_to_cnt != TW'(LOCK_TIMEOUT)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign o_stable  = i_stab_en & r_sync2 &
    (r_stab_cnt == SW'(LOCK_STABLE - 1));
  assign o_timeout = i_to_en &
    (r_to_cnt == TW'(LOCK_TIMEOUT - 1));

endmodule

// File: rtl/pll_reconfig_seq.sv
// Run-time Cyclone V fPLL reprogramming through the reconfig
// Avalon-MM slave. Optional dynamic phase shift: PLL_RCFG_DPS_EN.
// Ports: cfg_* profile request (valid/ready), mgmt_* Avalon
// master, pll_locked (async), busy / done / err status.
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_CLK      = 1,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 1048576
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [17:0]              cfg_n,
  input  logic [17:0]              cfg_m,
  input  logic [31:0]              cfg_k,
  input  logic [NUM_CLK*18-1:0]    cfg_c,
`ifdef PLL_RCFG_DPS_EN
  input  logic [NUM_CLK*17-1:0]    cfg_phase,
`endif
  output logic [5:0]               mgmt_address,
  output logic                     mgmt_write,
  output logic [31:0]              mgmt_writedata,
  input  logic                     mgmt_waitrequest,
  input  logic                     pll_locked,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  state_e r_state;
  state_e w_nxt_state;

  cnt_word_t                 r_n;
  cnt_word_t                 r_m;
  logic [31:0]               r_k;
  logic [NUM_CLK*CNT_W-1:0]  r_c;
`ifdef PLL_RCFG_DPS_EN
  logic [NUM_CLK*PH_W-1:0]   r_phase;
`endif

  logic [4:0]  r_idx;
  logic [4:0]  w_nxt_idx;
  logic        r_wr;
  logic        w_nxt_wr;
  logic [5:0]  r_addr;
  logic [5:0]  w_nxt_addr;
  logic [31:0] r_wdata;
  logic [31:0] w_nxt_wdata;
  logic        r_busy;
  logic        w_nxt_busy;
  logic        r_done;
  logic        w_nxt_done;
  logic        r_err;
  logic        w_nxt_err;

  logic w_accept;
  logic w_wr_ok;
  logic w_to_clr;
  logic w_stable;
  logic w_timeout;

  logic [4:0]  w_c_sel;
  cnt_word_t   w_c_word;
  logic [31:0] w_c_data;

  assign w_wr_ok = r_wr & ~mgmt_waitrequest;

  // C counter to be written next: 0 when leaving WR_K,
  // otherwise the one after the current index.
  always_comb begin
    w_c_sel  = (r_state == WR_K) ? 5'd0 : r_idx + 5'd1;
    w_c_word = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      if (5'(i) == w_c_sel) begin
        w_c_word = r_c[i*CNT_W +: CNT_W];
      end
    end
    w_c_data = {9'b0, w_c_sel, w_c_word};
  end

`ifdef PLL_RCFG_DPS_EN
  logic            w_dps_first_vld;
  logic [4:0]      w_dps_first;
  logic            w_dps_next_vld;
  logic [4:0]      w_dps_next;
  logic [4:0]      w_dps_sel;
  logic [PH_W-1:0] w_ph_word;
  logic [31:0]     w_dps_data;

  // Lowest counter with non-zero steps (first), and lowest
  // one above the current index (next).
  always_comb begin
    w_dps_first_vld = 1'b0;
    w_dps_first     = '0;
    w_dps_next_vld  = 1'b0;
    w_dps_next      = '0;
    for (int i = NUM_CLK - 1; i >= 0; i--) begin
      if (r_phase[i*PH_W +: 16] != 16'd0) begin
        w_dps_first_vld = 1'b1;
        w_dps_first     = 5'(i);
        if (5'(i) > r_idx) begin
          w_dps_next_vld = 1'b1;
          w_dps_next     = 5'(i);
        end
      end
    end
  end

  always_comb begin
    w_dps_sel = (r_state == WR_DPS) ?
      w_dps_next : w_dps_first;
    w_ph_word = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      if (5'(i) == w_dps_sel) begin
        w_ph_word = r_phase[i*PH_W +: PH_W];
      end
    end
    w_dps_data = {10'b0, w_ph_word[16],
                  w_dps_sel, w_ph_word[15:0]};
  end
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_wr    = r_wr;
    w_nxt_addr  = r_addr;
    w_nxt_wdata = r_wdata;
    w_nxt_busy  = r_busy;
    w_nxt_done  = 1'b0;
    w_nxt_err   = r_err;
    w_accept    = 1'b0;
    w_to_clr    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cfg_valid) begin
          w_accept    = 1'b1;
          w_nxt_state = WR_MODE;
          w_nxt_wr    = 1'b1;
          w_nxt_addr  = ADDR_MODE;
          w_nxt_wdata = 32'd0;
          w_nxt_busy  = 1'b1;
          w_nxt_err   = 1'b0;
        end
      end
      WR_MODE: begin
        if (w_wr_ok) begin
          w_nxt_state = WR_N;
          w_nxt_addr  = ADDR_N;
          w_nxt_wdata = cnt_data(r_n);
        end
      end
      WR_N: begin
        if (w_wr_ok) begin
          w_nxt_state = WR_M;
          w_nxt_addr  = ADDR_M;
          w_nxt_wdata = cnt_data(r_m);
        end
      end
      WR_M: begin
        if (w_wr_ok) begin
          w_nxt_state = WR_K;
          w_nxt_addr  = ADDR_K;
          w_nxt_wdata = r_k;
        end
      end
      WR_K: begin
        if (w_wr_ok) begin
          w_nxt_state = WR_C;
          w_nxt_idx   = 5'd0;
          w_nxt_addr  = ADDR_C;
          w_nxt_wdata = w_c_data;
        end
      end
      WR_C: begin
        if (w_wr_ok) begin
          if (r_idx == 5'(NUM_CLK - 1)) begin
`ifdef PLL_RCFG_DPS_EN
            if (w_dps_first_vld) begin
              w_nxt_state = WR_DPS;
              w_nxt_idx   = w_dps_first;
              w_nxt_addr  = ADDR_DPS;
              w_nxt_wdata = w_dps_data;
            end else
`endif
            begin
              w_nxt_state = WR_START;
              w_nxt_addr  = ADDR_START;
              w_nxt_wdata = 32'd1;
            end
          end else begin
            w_nxt_idx   = w_c_sel;
            w_nxt_wdata = w_c_data;
          end
        end
      end
`ifdef PLL_RCFG_DPS_EN
      WR_DPS: begin
        if (w_wr_ok) begin
          if (w_dps_next_vld) begin
            w_nxt_idx   = w_dps_next;
            w_nxt_wdata = w_dps_data;
          end else begin
            w_nxt_state = WR_START;
            w_nxt_addr  = ADDR_START;
            w_nxt_wdata = 32'd1;
          end
        end
      end
`endif
      WR_START: begin
        if (w_wr_ok) begin
          w_nxt_state = WAIT_RCFG;
          w_nxt_wr    = 1'b0;
          w_to_clr    = 1'b1;
        end
      end
      WAIT_RCFG: begin
        if (w_timeout) begin
          w_nxt_state = IDLE;
          w_nxt_busy  = 1'b0;
          w_nxt_err   = 1'b1;
        end else if (!mgmt_waitrequest) begin
          w_nxt_state = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        // Stability beats timeout on the same cycle.
        if (w_stable) begin
          w_nxt_state = IDLE;
          w_nxt_busy  = 1'b0;
          w_nxt_done  = 1'b1;
        end else if (w_timeout) begin
          w_nxt_state = IDLE;
          w_nxt_busy  = 1'b0;
          w_nxt_err   = 1'b1;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_wr    = 1'b0;
        w_nxt_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_wr    <= w_nxt_wr;
      r_addr  <= w_nxt_addr;
      r_wdata <= w_nxt_wdata;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
      r_err   <= w_nxt_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_n     <= '0;
      r_m     <= '0;
      r_k     <= '0;
      r_c     <= '0;
`ifdef PLL_RCFG_DPS_EN
      r_phase <= '0;
`endif
    end else if (w_accept) begin
      r_n     <= cfg_n;
      r_m     <= cfg_m;
      r_k     <= cfg_k;
      r_c     <= cfg_c;
`ifdef PLL_RCFG_DPS_EN
      r_phase <= cfg_phase;
`endif
    end
  end

  pll_lock_monitor #(
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_lock (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_locked  (pll_locked),
    .i_stab_en (r_state == WAIT_LOCK),
    .i_to_clr  (w_to_clr),
    .i_to_en   ((r_state == WAIT_RCFG) ||
                (r_state == WAIT_LOCK)),
    .o_stable  (w_stable),
    .o_timeout (w_timeout)
  );

  assign cfg_ready      = (r_state == IDLE);
  assign mgmt_write     = r_wr;
  assign mgmt_address   = r_addr;
  assign mgmt_writedata = r_wdata;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Testbench for pll_reconfig_seq: randomized profiles, stalls
// and lock patterns against a transaction-level model.
module tb_pll_reconfig_seq;

  localparam int NCLK  = 3;
  localparam int LSTAB = 16;
  localparam int LTO   = 64;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b1;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_ready;
  logic [17:0]          cfg_n = '0;
  logic [17:0]          cfg_m = '0;
  logic [31:0]          cfg_k = '0;
  logic [NCLK*18-1:0]   cfg_c = '0;
`ifdef PLL_RCFG_DPS_EN
  logic [NCLK*17-1:0]   cfg_phase = '0;
`endif
  logic [5:0]           mgmt_address;
  logic                 mgmt_write;
  logic [31:0]          mgmt_writedata;
  logic                 mgmt_waitrequest = 1'b0;
  logic                 pll_locked = 1'b0;
  logic                 busy;
  logic                 done;
  logic                 err;

  pll_reconfig_seq #(
    .NUM_CLK      (NCLK),
    .LOCK_STABLE  (LSTAB),
    .LOCK_TIMEOUT (LTO)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_n            (cfg_n),
    .cfg_m            (cfg_m),
    .cfg_k            (cfg_k),
    .cfg_c            (cfg_c),
`ifdef PLL_RCFG_DPS_EN
    .cfg_phase        (cfg_phase),
`endif
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit g_err_exp = 1'b0;

  logic [17:0] p_n;
  logic [17:0] p_m;
  logic [31:0] p_k;
  logic [17:0] p_c [NCLK];
`ifdef PLL_RCFG_DPS_EN
  logic [16:0] p_ph [NCLK];
`endif
  logic [37:0] exp_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic rand_profile();
    p_n = 18'($urandom);
    p_m = 18'($urandom);
    p_k = $urandom;
    for (int i = 0; i < NCLK; i++) begin
      p_c[i] = 18'($urandom);
`ifdef PLL_RCFG_DPS_EN
      p_ph[i] = ($urandom_range(0, 1) != 0) ?
        17'($urandom) : 17'd0;
`endif
    end
  endtask

  // Expected Avalon writes {addr, data} in issue order.
  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back({6'h00, 32'h0});
    exp_q.push_back({6'h03, 14'b0, p_n});
    exp_q.push_back({6'h04, 14'b0, p_m});
    exp_q.push_back({6'h07, p_k});
    for (int i = 0; i < NCLK; i++)
      exp_q.push_back({6'h05, 9'b0, 5'(i), p_c[i]});
`ifdef PLL_RCFG_DPS_EN
    for (int i = 0; i < NCLK; i++)
      if (p_ph[i][15:0] != 16'd0)
        exp_q.push_back({6'h06, 10'b0, p_ph[i][16],
                         5'(i), p_ph[i][15:0]});
`endif
    exp_q.push_back({6'h02, 32'd1});
  endtask

  task automatic accept();
    cfg_n = p_n;
    cfg_m = p_m;
    cfg_k = p_k;
    for (int i = 0; i < NCLK; i++)
      cfg_c[i*18 +: 18] = p_c[i];
`ifdef PLL_RCFG_DPS_EN
    for (int i = 0; i < NCLK; i++)
      cfg_phase[i*17 +: 17] = p_ph[i];
`endif
    cfg_valid = 1'b1;
    pll_locked = 1'b0;
    mgmt_waitrequest = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_n = 18'($urandom);
    cfg_m = 18'($urandom);
    cfg_k = $urandom;
    cfg_c = {NCLK{18'($urandom)}};
`ifdef PLL_RCFG_DPS_EN
    cfg_phase = {NCLK{17'($urandom)}};
`endif
    g_err_exp = 1'b0;
  endtask

  // mode: 0 locked high, 1 one low blip at count 10,
  // 2 never locks, 3 random
  task automatic run_profile(input int stall_max,
                             input int rcfg_stall,
                             input int mode);
    int stall_left;
    int rcfg_left;
    int to_cnt;
    int stab;
    bit in_rcfg;
    bit ended;
    bit l1;
    bit l2;
    bit lv;
    bit w;
    bit exp_done;
    logic [37:0] head;
    build_exp();
    chk("err_sticky", err, g_err_exp);
    chk("ready_idle", cfg_ready, 1);
    accept();
    chk("acc_busy", busy, 1);
    chk("acc_err", err, 0);
    chk("acc_ready", cfg_ready, 0);
    stall_left = $urandom_range(0, stall_max);
    while (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("wr_strobe", mgmt_write, 1);
      chk("wr_addr", mgmt_address, head[37:32]);
      chk("wr_data", mgmt_writedata, head[31:0]);
      if (stall_left > 0) begin
        mgmt_waitrequest = 1'b1;
        stall_left--;
      end else begin
        mgmt_waitrequest = 1'b0;
        void'(exp_q.pop_front());
        stall_left = $urandom_range(0, stall_max);
      end
      @(negedge clk);
    end
    chk("wr_end", mgmt_write, 0);
    chk("rcfg_busy", busy, 1);
    rcfg_left = rcfg_stall;
    in_rcfg = 1'b1;
    ended = 1'b0;
    to_cnt = 0;
    stab = 0;
    l1 = 1'b0;
    l2 = 1'b0;
    for (int k = 1; k <= LTO + 8 && !ended; k++) begin
      w = (rcfg_left > 0);
      if (rcfg_left > 0) rcfg_left--;
      mgmt_waitrequest = w;
      unique case (mode)
        0: lv = 1'b1;
        1: lv = (k != 11);
        2: lv = 1'b0;
        default: lv = ($urandom_range(0, 3) != 0);
      endcase
      pll_locked = lv;
      @(negedge clk);
      exp_done = 1'b0;
      to_cnt++;
      if (in_rcfg) begin
        if (to_cnt == LTO) begin
          g_err_exp = 1'b1;
          ended = 1'b1;
        end else if (!w) begin
          in_rcfg = 1'b0;
        end
      end else begin
        stab = l2 ? stab + 1 : 0;
        if (stab == LSTAB) begin
          exp_done = 1'b1;
          ended = 1'b1;
        end else if (to_cnt == LTO) begin
          g_err_exp = 1'b1;
          ended = 1'b1;
        end
      end
      l2 = l1;
      l1 = lv;
      chk("done", done, exp_done);
      chk("err", err, g_err_exp);
      chk("busy", busy, !ended);
    end
    chk("ready_end", cfg_ready, 1);
    mgmt_waitrequest = 1'b0;
    pll_locked = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic reset_mid();
    rand_profile();
    accept();
    repeat (3) @(negedge clk);
    chk("rst_in_k", mgmt_address, 6'h07);
    mgmt_waitrequest = 1'b1;
    @(negedge clk);
    chk("rst_k_held", mgmt_address, 6'h07);
    chk("rst_k_wr", mgmt_write, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_wr", mgmt_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_addr", mgmt_address, 0);
    @(negedge clk);
    reset_n = 1'b1;
    mgmt_waitrequest = 1'b0;
    g_err_exp = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("r_wr", mgmt_write, 0);
    chk("r_addr", mgmt_address, 0);
    chk("r_data", mgmt_writedata, 0);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_err", err, 0);
    chk("r_ready", cfg_ready, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 167 MHz profile, no stalls
    rand_profile();
    p_n = 18'h10000;
    p_m = 18'h20605;
    p_k = 32'h3EEC2C98;
    p_c[0] = 18'h20302;
`ifdef PLL_RCFG_DPS_EN
    for (int i = 0; i < NCLK; i++) p_ph[i] = '0;
`endif
    run_profile(0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      rand_profile();
      run_profile(3, $urandom_range(0, 3), 0);
    end

    rand_profile();
    run_profile(1, 0, 1);

    rand_profile();
    run_profile(2, 1, 2);

    rand_profile();
    run_profile(3, 0, 0);

    reset_mid();
    rand_profile();
    run_profile(2, 0, 0);

`ifdef PLL_RCFG_DPS_EN
    rand_profile();
    p_ph[0] = 17'd0;
    p_ph[1] = {1'b1, 16'd5};
    p_ph[2] = 17'd0;
    run_profile(2, 0, 0);
`endif

    for (int i = 0; i < 4; i++) begin
      rand_profile();
      run_profile(3, $urandom_range(0, 2), 3);
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Sequencer that reprograms a reconfigurable Cyclone V fractional PLL at run time through the altera_pll_reconfig Avalon-MM management slave.
- Accepts one complete clock profile per request: N, M, fractional K and NUM_CLK output C counters.
- Writes the registers in a fixed order, triggers start, then waits for stable lock.
- Sits between the memory-test control logic and the PLL wrapper; it changes the memory clock (e.g. 167 MHz) without re-synthesis.

Parameters:
- NUM_CLK, 1, number of PLL output counters programmed (legal 1..18); the C counter select field is the counter index.
- LOCK_STABLE, 16, consecutive cycles pll_locked must stay high before completion.
- LOCK_TIMEOUT, 1048576, cycles allowed from start accepted to stable lock before err.

Ports:
- clk  in  1  management clock; all logic is on this edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  profile request.
- cfg_ready  out  1  high only in IDLE.
- cfg_n  in  18  N register word: [7:0] lo, [15:8] hi, [16] bypass, [17] odd.
- cfg_m  in  18  M register word, same encoding as cfg_n.
- cfg_k  in  32  fractional K value.
- cfg_c  in  NUM_CLK*18  C counter i occupies [18*i+17:18*i], same encoding as cfg_n.
- mgmt_address  out  6  reconfig register address.
- mgmt_write  out  1  Avalon write strobe.
- mgmt_writedata  out  32  Avalon write data.
- mgmt_waitrequest  in  1  Avalon waitrequest.
- pll_locked  in  1  PLL locked (asynchronous; synchronised internally by 2 flops).
- busy  out  1  high from the accept cycle until return to IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky lock timeout flag; cleared by the next accepted request.

Behaviour:
- Reset values: mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, done=0, err=0, cfg_ready=1 (IDLE).
- Handshake: a request is accepted on a cycle with cfg_valid&cfg_ready. All cfg_* inputs are latched on that cycle. Inputs are ignored while busy.
- States: IDLE → WR_MODE → WR_N → WR_M → WR_K → WR_C → WR_START → WAIT_RCFG → WAIT_LOCK → IDLE.
- Register writes in each WR_* state:
  - WR_MODE: addr 0x00, data 0 (waitrequest mode).
  - WR_N: addr 0x03, data {14'b0, n}.
  - WR_M: addr 0x04, data {14'b0, m}.
  - WR_K: addr 0x07, data k.
  - WR_C: addr 0x05, data {9'b0, idx[4:0], c[idx]}. The idx counter runs 0..NUM_CLK-1; the state is held until idx==NUM_CLK-1 is accepted.
  - WR_START: addr 0x02, data 1.
- Write rule: address and data are registered and stable while mgmt_write=1. A write completes on a cycle with mgmt_write=1 and mgmt_waitrequest=0. The next write is issued the following cycle, so there is no idle gap. With waitrequest tied low, a 1-clock config takes 6 consecutive write cycles.
- WAIT_RCFG: mgmt_write=0. Stay until mgmt_waitrequest=0 (the reconfig IP holds it high during the update); minimum 1 cycle.
- WAIT_LOCK: the stability counter increments while synchronised locked=1 and clears to 0 when it drops.
  - Counter reaching LOCK_STABLE: done pulse, go to IDLE.
- Timeout counter: starts at 0 on start-write accept and increments every cycle in WAIT_RCFG/WAIT_LOCK.
  - Reaching LOCK_TIMEOUT: err=1, no done, go to IDLE.
  - If timeout and stability are reached on the same cycle, success wins.
- busy: set on the accept cycle and cleared on entry to IDLE. done and busy-fall occur in the same cycle.
- Reset mid-operation: the sequence is abandoned immediately and mgmt_write drops asynchronously. The PLL is left partially programmed; the owner must re-issue a profile.
- Counter widths: stability counter $clog2(LOCK_STABLE+1), timeout counter $clog2(LOCK_TIMEOUT+1); neither wraps (both saturate).

Optional Feature:
- Macro PLL_RCFG_DPS_EN.
- When defined:
  - Extra input cfg_phase (NUM_CLK*17): per counter, [15:0] step count and [16] direction (1=up).
  - State WR_DPS sits between WR_C and WR_START and writes addr 0x06, data {10'b0, dir, idx[4:0], steps}.
  - Writes are made only for counters with steps≠0, in index order; if all are zero, WR_DPS takes zero cycles.
- When undefined: no port, no state; phase shifts are untouched.

Decomposition:
- Package pll_reconfig_pkg holds:
  - register address localparams (MODE, STATUS, START, N, M, C, DPS, K);
  - the 18-bit counter-word typedef with its field offsets;
  - the state enum.
- One sub-module, pll_lock_monitor: the 2-flop synchroniser, stability counter and timeout counter, giving stable and timeout outputs to the FSM.

Test Plan:
- 167 MHz profile, NUM_CLK=1, waitrequest=0: n=0x10000, m=0x20605, k=0x3EEC2C98, c0=0x20302 → writes (0x00,0), (0x03,0x00010000), (0x04,0x00020605), (0x07,0x3EEC2C98), (0x05,0x00020302), (0x02,1) on 6 consecutive cycles. Then locked high 16 cycles → done pulse; busy low on the same cycle.
- NUM_CLK=3 with waitrequest randomly high 0–3 cycles per write → address/data held while stalled; C writes carry select 0,1,2 in bits [22:18]; write count = 8.
- pll_locked toggles low at stability count 10, then stays high → counter restarts; done only after 16 fresh consecutive high cycles.
- LOCK_TIMEOUT=64, pll_locked held low → err=1 at cycle 64 after start accept, no done, cfg_ready=1. Next request clears err on its accept cycle.
- reset_n asserted during WR_K with waitrequest high → mgmt_write=0 immediately, busy=0, cfg_ready=1. A new request restarts at WR_MODE.
- PLL_RCFG_DPS_EN, NUM_CLK=2, phase0=0, phase1={1,16'd5} → exactly one DPS write (0x06, 0x0021_0005) between the last C write and start.
